// File: rtl/sc_fifo_gen.sv
// Single-clock FIFO with selectable standard / first-word-fall-through read mode,
// programmable almost-full / almost-empty thresholds, sticky error flags,
// synchronous clear and a full-range (0..DEPTH) occupancy count.
module sc_fifo_gen #(
    parameter int unsigned DW    = 8,
    parameter int unsigned AW    = 3,
    parameter int unsigned FWFT  = 0,
    parameter int unsigned AF_TH = (2 ** AW) - 2,
    parameter int unsigned AE_TH = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic [DW-1:0] din,
    input  logic          wr,
    output logic [DW-1:0] dout,
    input  logic          rd,
    output logic [AW-1:0] wc,
    output logic [AW-1:0] rc,
    output logic [AW:0]   dc,
    output logic          full,
    output logic          empty,
    output logic          almost_full,
    output logic          almost_empty,
    output logic          overflow,
    output logic          underflow
);

    localparam int unsigned Depth  = 2 ** AW;
    localparam logic [AW:0] DcFull = (AW + 1)'(Depth);
    localparam logic [AW:0] AfTh   = (AW + 1)'(AF_TH);
    localparam logic [AW:0] AeTh   = (AW + 1)'(AE_TH);

    logic [DW-1:0] mem_q [Depth];

    logic [AW-1:0] wc_q, wc_d;
    logic [AW-1:0] rc_q, rc_d;
    logic [AW:0]   dc_q, dc_d;
    logic [DW-1:0] dout_q, dout_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;

    logic rd_acc;
    logic wr_acc;

    // Status flags are pure decodes of the registered count.
    assign empty        = (dc_q == '0);
    assign full         = (dc_q == DcFull);
    assign almost_full  = (dc_q >= AfTh);
    assign almost_empty = (dc_q <= AeTh);

    // A read frees a slot in the same cycle, so a full FIFO still accepts a paired write.
    assign rd_acc = rd & ~empty;
    assign wr_acc = wr & (~full | rd_acc);

    // Next-state for pointers, count, registered read data and sticky errors.
    always_comb begin
        wc_d   = wc_q;
        rc_d   = rc_q;
        dc_d   = dc_q;
        dout_d = dout_q;
        ovf_d  = ovf_q;
        unf_d  = unf_q;
        if (clr) begin
            wc_d   = '0;
            rc_d   = '0;
            dc_d   = '0;
            dout_d = '0;
            ovf_d  = 1'b0;
            unf_d  = 1'b0;
        end else begin
            if (wr_acc) wc_d = wc_q + AW'(1);
            if (rd_acc) begin
                rc_d = rc_q + AW'(1);
                // Only standard mode needs the output register.
                if (FWFT == 0) dout_d = mem_q[rc_q];
            end
            unique case ({wr_acc, rd_acc})
                2'b10:   dc_d = dc_q + (AW + 1)'(1);
                2'b01:   dc_d = dc_q - (AW + 1)'(1);
                default: dc_d = dc_q;
            endcase
            if (wr && !wr_acc) ovf_d = 1'b1;
            if (rd && empty)   unf_d = 1'b1;
        end
    end

    // Control state, asynchronously reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wc_q   <= '0;
            rc_q   <= '0;
            dc_q   <= '0;
            dout_q <= '0;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
        end else begin
            wc_q   <= wc_d;
            rc_q   <= rc_d;
            dc_q   <= dc_d;
            dout_q <= dout_d;
            ovf_q  <= ovf_d;
            unf_q  <= unf_d;
        end
    end

    // Storage array; deliberately not reset so it can map to RAM.
    always_ff @(posedge clk) begin
        if (wr_acc && !clr) mem_q[wc_q] <= din;
    end

    // FWFT presents the head word directly; forced to zero while empty so reset reads as 0.
    assign dout = (FWFT != 0) ? (empty ? '0 : mem_q[rc_q]) : dout_q;

    assign wc        = wc_q;
    assign rc        = rc_q;
    assign dc        = dc_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;

endmodule

// File: tb/tb_sc_fifo_gen.sv
// Directed bench for sc_fifo_gen: a standard-mode and an FWFT-mode instance share stimulus.
module tb_sc_fifo_gen;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clr;
    logic       wr;
    logic       rd;
    logic [7:0] din;

    logic [7:0] s_dout, f_dout;
    logic [2:0] s_wc, s_rc, f_wc, f_rc;
    logic [3:0] s_dc, f_dc;
    logic       s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
    logic       f_full, f_empty, f_af, f_ae, f_ovf, f_unf;

    // {wc, rc, dc, dout, empty, full, almost_full, almost_empty, overflow, underflow}
    logic [23:0] s_stat, f_stat;
    localparam logic [23:0] RstStat = {3'd0, 3'd0, 4'd0, 8'h00, 6'b100100};

    assign s_stat = {s_wc, s_rc, s_dc, s_dout, s_empty, s_full, s_af, s_ae, s_ovf, s_unf};
    assign f_stat = {f_wc, f_rc, f_dc, f_dout, f_empty, f_full, f_af, f_ae, f_ovf, f_unf};

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sc_fifo_gen #(.DW(8), .AW(3), .FWFT(0), .AF_TH(6), .AE_TH(2)) u_std (
        .clk(clk), .rst_n(rst_n), .clr(clr), .din(din), .wr(wr), .dout(s_dout), .rd(rd),
        .wc(s_wc), .rc(s_rc), .dc(s_dc), .full(s_full), .empty(s_empty),
        .almost_full(s_af), .almost_empty(s_ae), .overflow(s_ovf), .underflow(s_unf)
    );

    sc_fifo_gen #(.DW(8), .AW(3), .FWFT(1), .AF_TH(6), .AE_TH(2)) u_fwft (
        .clk(clk), .rst_n(rst_n), .clr(clr), .din(din), .wr(wr), .dout(f_dout), .rd(rd),
        .wc(f_wc), .rc(f_rc), .dc(f_dc), .full(f_full), .empty(f_empty),
        .almost_full(f_af), .almost_empty(f_ae), .overflow(f_ovf), .underflow(f_unf)
    );

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr  = 1'b0;
        rd  = 1'b0;
        clr = 1'b0;
        din = 8'h00;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        cycle();
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++;
        if (s_stat !== RstStat) begin
            n_err++;
            $display("FAIL reset_std: got %h want %h", s_stat, RstStat);
        end
        n_vec++;
        if (f_stat !== RstStat) begin
            n_err++;
            $display("FAIL reset_fwft: got %h want %h", f_stat, RstStat);
        end
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 8; i++) begin
            wr  = 1'b1;
            din = 8'(i * 17);
            cycle();
            n_vec++;
            if (s_dc !== 4'(i)) begin
                n_err++;
                $display("FAIL fill_dc[%0d]: got %0d want %0d", i, s_dc, i);
            end
            n_vec++;
            if ({s_ae, s_af, s_full} !== {(i <= 2), (i >= 6), (i == 8)}) begin
                n_err++;
                $display("FAIL fill_flags[%0d]: ae/af/full got %b want %b", i,
                         {s_ae, s_af, s_full}, {(i <= 2), (i >= 6), (i == 8)});
            end
        end
        din = 8'h99;
        cycle();
        wr = 1'b0;
        n_vec++;
        if ({s_dc, s_full, s_ovf} !== {4'd8, 1'b1, 1'b1}) begin
            n_err++;
            $display("FAIL fill_overflow: dc/full/ovf got %0d/%b/%b want 8/1/1",
                     s_dc, s_full, s_ovf);
        end
    endtask

    task automatic test_drain();
        for (int i = 1; i <= 8; i++) begin
            rd = 1'b1;
            cycle();
            n_vec++;
            if (s_dout !== 8'(i * 17)) begin
                n_err++;
                $display("FAIL drain_dout[%0d]: got %h want %h", i, s_dout, 8'(i * 17));
            end
            n_vec++;
            if (s_empty !== (i == 8)) begin
                n_err++;
                $display("FAIL drain_empty[%0d]: got %b want %b", i, s_empty, (i == 8));
            end
        end
        cycle();
        rd = 1'b0;
        n_vec++;
        if ({s_unf, s_dout} !== {1'b1, 8'h88}) begin
            n_err++;
            $display("FAIL drain_underflow: unf/dout got %b/%h want 1/88", s_unf, s_dout);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] q[$];
        logic [7:0] d;
        logic [7:0] exp;
        do_reset();
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 5; i++) begin
                d = 8'($urandom_range(0, 255));
                q.push_back(d);
                wr  = 1'b1;
                din = d;
                cycle();
            end
            wr = 1'b0;
            for (int i = 0; i < 5; i++) begin
                rd = 1'b1;
                cycle();
                exp = q.pop_front();
                n_vec++;
                if (s_dout !== exp) begin
                    n_err++;
                    $display("FAIL wrap_dout[%0d.%0d]: got %h want %h", r, i, s_dout, exp);
                end
            end
            rd = 1'b0;
        end
        n_vec++;
        if ({s_wc, s_rc, s_dc, s_empty} !== {3'd2, 3'd2, 4'd0, 1'b1}) begin
            n_err++;
            $display("FAIL wrap_final: wc/rc/dc/empty got %0d/%0d/%0d/%b want 2/2/0/1",
                     s_wc, s_rc, s_dc, s_empty);
        end
    endtask

    task automatic test_simultaneous();
        logic [7:0] exp_order [8];
        exp_order = '{8'hC3, 8'hC4, 8'hC5, 8'hC6, 8'hC7, 8'hD0, 8'hD1, 8'hD2};
        do_reset();
        for (int i = 0; i < 8; i++) begin
            wr  = 1'b1;
            din = 8'hC0 + 8'(i);
            cycle();
        end
        for (int i = 0; i < 3; i++) begin
            wr  = 1'b1;
            rd  = 1'b1;
            din = 8'hD0 + 8'(i);
            cycle();
            n_vec++;
            if ({s_dc, s_full, s_ovf, s_dout} !== {4'd8, 1'b1, 1'b0, 8'hC0 + 8'(i)}) begin
                n_err++;
                $display("FAIL simul_full[%0d]: dc/full/ovf/dout got %0d/%b/%b/%h want 8/1/0/%h",
                         i, s_dc, s_full, s_ovf, s_dout, 8'hC0 + 8'(i));
            end
        end
        wr = 1'b0;
        for (int i = 0; i < 8; i++) begin
            rd = 1'b1;
            cycle();
            n_vec++;
            if (s_dout !== exp_order[i]) begin
                n_err++;
                $display("FAIL simul_order[%0d]: got %h want %h", i, s_dout, exp_order[i]);
            end
        end
        rd = 1'b0;
        do_reset();
        wr  = 1'b1;
        rd  = 1'b1;
        din = 8'hEE;
        cycle();
        idle();
        n_vec++;
        if ({s_dc, s_unf, s_ovf} !== {4'd1, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL simul_empty: dc/unf/ovf got %0d/%b/%b want 1/1/0", s_dc, s_unf, s_ovf);
        end
        rd = 1'b1;
        cycle();
        rd = 1'b0;
        n_vec++;
        if (s_dout !== 8'hEE) begin
            n_err++;
            $display("FAIL simul_empty_data: got %h want ee", s_dout);
        end
    endtask

    task automatic test_fwft();
        do_reset();
        wr  = 1'b1;
        din = 8'hA5;
        cycle();
        wr = 1'b0;
        n_vec++;
        if ({f_empty, f_dout} !== {1'b0, 8'hA5}) begin
            n_err++;
            $display("FAIL fwft_first: empty/dout got %b/%h want 0/a5", f_empty, f_dout);
        end
        wr  = 1'b1;
        din = 8'h5A;
        cycle();
        wr = 1'b0;
        n_vec++;
        if ({f_dc, f_dout} !== {4'd2, 8'hA5}) begin
            n_err++;
            $display("FAIL fwft_hold: dc/dout got %0d/%h want 2/a5", f_dc, f_dout);
        end
        rd = 1'b1;
        cycle();
        n_vec++;
        if ({f_dc, f_dout} !== {4'd1, 8'h5A}) begin
            n_err++;
            $display("FAIL fwft_pop: dc/dout got %0d/%h want 1/5a", f_dc, f_dout);
        end
        cycle();
        rd = 1'b0;
        n_vec++;
        if ({f_empty, f_dc, f_unf} !== {1'b1, 4'd0, 1'b0}) begin
            n_err++;
            $display("FAIL fwft_empty: empty/dc/unf got %b/%0d/%b want 1/0/0",
                     f_empty, f_dc, f_unf);
        end
    endtask

    // Leaves dc=4, wc=5, rc=1, dout=31 and underflow set.
    task automatic prep_dc4();
        rd = 1'b1;
        cycle();
        rd = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            wr  = 1'b1;
            din = 8'h30 + 8'(i);
            cycle();
        end
        wr = 1'b0;
        rd = 1'b1;
        cycle();
        rd = 1'b0;
    endtask

    task automatic test_reset_clear();
        do_reset();
        prep_dc4();
        n_vec++;
        if ({s_wc, s_rc, s_dc, s_dout, s_unf} !== {3'd5, 3'd1, 4'd4, 8'h31, 1'b1}) begin
            n_err++;
            $display("FAIL prep_async: wc/rc/dc/dout/unf got %0d/%0d/%0d/%h/%b want 5/1/4/31/1",
                     s_wc, s_rc, s_dc, s_dout, s_unf);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (s_stat !== RstStat) begin
            n_err++;
            $display("FAIL async_reset_std: got %h want %h", s_stat, RstStat);
        end
        n_vec++;
        if (f_stat !== RstStat) begin
            n_err++;
            $display("FAIL async_reset_fwft: got %h want %h", f_stat, RstStat);
        end
        #1;
        rst_n = 1'b1;
        cycle();
        prep_dc4();
        n_vec++;
        if ({s_dc, s_dout} !== {4'd4, 8'h31}) begin
            n_err++;
            $display("FAIL prep_clr: dc/dout got %0d/%h want 4/31", s_dc, s_dout);
        end
        clr = 1'b1;
        wr  = 1'b1;
        din = 8'h77;
        cycle();
        idle();
        n_vec++;
        if (s_stat !== RstStat) begin
            n_err++;
            $display("FAIL clear_std: got %h want %h", s_stat, RstStat);
        end
        n_vec++;
        if (f_stat !== RstStat) begin
            n_err++;
            $display("FAIL clear_fwft: got %h want %h", f_stat, RstStat);
        end
        cycle();
        n_vec++;
        if ({s_dc, s_empty} !== {4'd0, 1'b1}) begin
            n_err++;
            $display("FAIL clear_discard: dc/empty got %0d/%b want 0/1", s_dc, s_empty);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        idle();
        test_reset();
        test_fill();
        test_drain();
        test_wrap();
        test_simultaneous();
        test_fwft();
        test_reset_clear();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sc_fifo_gen.md
Name: sc_fifo_gen

Overview:
Parametrised single-clock FIFO, the successor to the current 2-port sync FIFO. It adds:
- a first-word-fall-through (FWFT) mode;
- programmable almost-full and almost-empty thresholds;
- sticky overflow and underflow error flags;
- a synchronous clear;
- a full-range data count.

It sits between producer and consumer logic in the same clock domain.

Parameters:
- DW, 8, data width in bits.
- AW, 3, address width; DEPTH = 2**AW words.
- FWFT, 0, read mode: 0 = standard (registered dout, 1-cycle latency), 1 = first-word-fall-through.
- AF_TH, 2**AW-2, almost_full asserts when dc >= AF_TH (range 1..DEPTH).
- AE_TH, 2, almost_empty asserts when dc <= AE_TH (range 0..DEPTH-1).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clr  in  1  synchronous clear, active high.
- din  in  DW  write data.
- wr  in  1  write request.
- dout  out  DW  read data.
- rd  in  1  read request.
- wc  out  AW  write pointer.
- rc  out  AW  read pointer.
- dc  out  AW+1  stored word count, 0..DEPTH.
- full  out  1  dc == DEPTH.
- empty  out  1  dc == 0.
- almost_full  out  1  dc >= AF_TH.
- almost_empty  out  1  dc <= AE_TH.
- overflow  out  1  sticky: a write was rejected.
- underflow  out  1  sticky: a read was rejected.

Behaviour:
- Reset (rst_n low, asynchronous, takes effect immediately):
  - wc=0, rc=0, dc=0, dout=0;
  - empty=1, full=0, almost_full=0, almost_empty=1;
  - overflow=0, underflow=0;
  - storage array not reset.
- clr=1 at an edge: same values as reset, applied synchronously. It overrides wr/rd in that cycle; no write or read occurs.
- Accept rules:
  - write accepted when wr & (!full | rd_acc);
  - read accepted (rd_acc) when rd & !empty;
  - full with wr & rd both high: both accepted, dc unchanged.
  - empty with wr & rd both high: only the write is accepted; underflow sets.
- Write accepted: mem[wc] <= din; wc <= wc+1, wrapping modulo DEPTH.
- Read accepted: rc <= rc+1, wrapping modulo DEPTH.
- dc update: +1 for write only, -1 for read only, unchanged for both or neither. It never exceeds DEPTH and never goes below 0.
- Flags: full, empty, almost_full and almost_empty are decoded from the registered dc and change on the same edge as dc.
- Error flags:
  - wr & !write_accepted sets overflow;
  - rd & empty sets underflow;
  - both stay set until rst_n or clr.
- FWFT=0 (standard mode):
  - on an accepted read, dout <= mem[rc] at that edge, so data is valid the cycle after rd;
  - dout holds its value when no read is accepted, including on rejected reads.
- FWFT=1:
  - dout = mem[rc] combinationally whenever empty=0;
  - a word written into an empty FIFO appears on dout in the cycle after the write edge, together with empty=0;
  - rd pops the current word and dout shows the next word after the edge;
  - dout value is don't-care while empty=1.
- Wrap-around: pointers wrap independently. Order is preserved across any number of wraps.
- Ordering and data integrity: data read out equals data written, in FIFO order; no loss and no duplication.

Test Plan (DW=8, AW=3, AF_TH=6, AE_TH=2 unless noted):
1. Fill: reset, then write 0x11,0x22,...,0x88 on consecutive cycles.
   - almost_empty drops when dc=3;
   - almost_full rises when dc=6;
   - full=1 and dc=8 after the 8th write;
   - a 9th write leaves dc=8 and mem intact, and sets overflow=1.
2. Drain (FWFT=0): from state 1, assert rd for 9 cycles.
   - dout = 0x11..0x88, each one cycle after its rd;
   - empty=1 after the 8th read;
   - the 9th rd sets underflow=1, and dout holds 0x88.
3. Wrap:
   - write 5 / read 5 / write 5 / read 5 with random data: outputs match inputs in order;
   - final wc=rc=2, dc=0, empty=1.
4. Simultaneous operations:
   - at full, wr&rd for 3 cycles: dc stays 8, full stays 1, no overflow, and the reads return the oldest 3 words;
   - at empty, wr&rd: dc becomes 1 and underflow=1.
5. FWFT=1:
   - write 0xA5 into an empty FIFO: the next cycle shows empty=0 and dout=0xA5 without rd;
   - write 0x5A, then rd: dout=0x5A after the edge;
   - rd again: empty=1.
6. Reset and clear mid-operation:
   - with dc=4, pulse rst_n low between edges: all outputs reach their reset values immediately, before the next edge;
   - repeat with clr=1 and wr=1 in the same cycle: reset values appear at that edge and the write is discarded.
